// File: rtl/rtmc_pkg.sv
// Shared widths, register map and handshake state type for the RTMC register block.
`timescale 1ns/1ps
package rtmc_pkg;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  localparam logic [ADDR_W-1:0] REG_ID        = 4'h0;
  localparam logic [ADDR_W-1:0] REG_SCRATCH   = 4'h1;
  localparam logic [ADDR_W-1:0] REG_CTRL      = 4'h2;
  localparam logic [ADDR_W-1:0] REG_GPO       = 4'h3;
  localparam logic [ADDR_W-1:0] REG_GPI_LO    = 4'h4;
  localparam logic [ADDR_W-1:0] REG_GPI_HI    = 4'h5;
  localparam logic [ADDR_W-1:0] REG_EDGE      = 4'h6;
  localparam logic [ADDR_W-1:0] REG_EDGE_MASK = 4'h7;
  localparam logic [ADDR_W-1:0] REG_MC        = 4'h8;
  localparam logic [ADDR_W-1:0] REG_MC_OE     = 4'h9;

  localparam logic [DATA_W-1:0] ID_VALUE = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_WAIT = 2'd2
  } reg_state_t;
endpackage

// File: rtl/rtmc_sync.sv
// Two-flop synchroniser for asynchronous inputs; cleared by reset so no stale level leaks out.
`timescale 1ns/1ps
module rtmc_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/rtmc_regs.sv
// Register-bus responder for the RTMC core: ID, scratch, GPIO, edge capture and coil registers.
//   state   | meaning
//   IDLE    | waiting for a strobe; access performed on the accepting edge
//   ACK     | reg_ack high for this single cycle
//   WAIT    | waiting for both strobes to drop before accepting again
`timescale 1ns/1ps
module rtmc_regs
  import rtmc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [ADDR_W-1:0] reg_addr,
  input  logic [DATA_W-1:0] reg_wdat,
  input  logic              reg_wr,
  input  logic              reg_rd,
  output logic [DATA_W-1:0] reg_rdat,
  output logic              reg_ack,
  input  logic [13:0]       gpi,
  output logic [6:0]        gpo,
  output logic [7:0]        mc,
  output logic [7:0]        mc_oe,
  output logic              irq
);
  reg_state_t state_q, state_d;

  logic [13:0]       gpi_s;
  logic [7:0]        gpi_prev_q;
  logic [DATA_W-1:0] scratch_q, ctrl_q, edge_q, edge_mask_q, mc_q, mc_oe_q, rdat_q;
  logic [6:0]        gpo_q;
  logic [DATA_W-1:0] rd_mux, edge_clr;
  logic [7:0]        edge_rise;
  logic              accept, wr_en, rd_en;

  rtmc_sync #(.W(14)) u_gpi_sync (
    .clk (clk),
    .rst (rst),
    .d   (gpi),
    .q   (gpi_s)
  );

  assign accept    = (state_q == ST_IDLE) && (reg_wr || reg_rd);
  assign wr_en     = accept && reg_wr;
  assign rd_en     = accept && reg_rd && !reg_wr;
  assign edge_rise = gpi_s[7:0] & ~gpi_prev_q;
  assign edge_clr  = (wr_en && reg_addr == REG_EDGE) ? reg_wdat : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (reg_wr || reg_rd) state_d = ST_ACK;
      ST_ACK:  state_d = ST_WAIT;
      ST_WAIT: if (!reg_wr && !reg_rd) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (reg_addr)
      REG_ID:        rd_mux = ID_VALUE;
      REG_SCRATCH:   rd_mux = scratch_q;
      REG_CTRL:      rd_mux = ctrl_q;
      REG_GPO:       rd_mux = {1'b0, gpo_q};
      REG_GPI_LO:    rd_mux = gpi_s[7:0];
      REG_GPI_HI:    rd_mux = {2'b00, gpi_s[13:8]};
      REG_EDGE:      rd_mux = edge_q;
      REG_EDGE_MASK: rd_mux = edge_mask_q;
      REG_MC:        rd_mux = mc_q;
      REG_MC_OE:     rd_mux = mc_oe_q;
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gpi_prev_q  <= '0;
      scratch_q   <= '0;
      ctrl_q      <= '0;
      gpo_q       <= '0;
      edge_q      <= '0;
      edge_mask_q <= '0;
      mc_q        <= '0;
      mc_oe_q     <= '0;
      rdat_q      <= '0;
    end else begin
      state_q    <= state_d;
      gpi_prev_q <= gpi_s[7:0];
      // A rise in the same cycle as a W1C of that bit keeps the bit set.
      edge_q     <= (edge_q & ~edge_clr) | edge_rise;
      if (rd_en) rdat_q <= rd_mux;
      if (wr_en) begin
        case (reg_addr)
          REG_SCRATCH:   scratch_q   <= reg_wdat;
          REG_CTRL:      ctrl_q      <= reg_wdat;
          REG_GPO:       gpo_q       <= reg_wdat[6:0];
          REG_EDGE_MASK: edge_mask_q <= reg_wdat;
          REG_MC:        mc_q        <= reg_wdat;
          REG_MC_OE:     mc_oe_q     <= reg_wdat;
          default: ;
        endcase
      end
    end
  end

  assign reg_ack  = (state_q == ST_ACK);
  assign reg_rdat = rdat_q;
  assign gpo      = gpo_q;
  assign mc       = mc_q;
  assign mc_oe    = mc_oe_q & {8{ctrl_q[0] & ena}};
  assign irq      = ena & |(edge_q & edge_mask_q);
endmodule

// File: tb/tb_rtmc_regs.sv
// Scoreboard bench for rtmc_regs: accesses push expected read data, a negedge monitor checks each ack.
`timescale 1ns/1ps
module tb_rtmc_regs;
  import rtmc_pkg::*;

  logic              clk = 1'b0;
  logic              rst, ena;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdat;
  logic              reg_wr, reg_rd;
  logic [DATA_W-1:0] reg_rdat;
  logic              reg_ack;
  logic [13:0]       gpi;
  logic [6:0]        gpo;
  logic [7:0]        mc, mc_oe;
  logic              irq;

  typedef struct {
    bit         chk;
    logic [7:0] rdat;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   ack_count = 0;
  bit   ack_prev = 0;

  rtmc_regs dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .reg_addr (reg_addr),
    .reg_wdat (reg_wdat),
    .reg_wr   (reg_wr),
    .reg_rd   (reg_rd),
    .reg_rdat (reg_rdat),
    .reg_ack  (reg_ack),
    .gpi      (gpi),
    .gpo      (gpo),
    .mc       (mc),
    .mc_oe    (mc_oe),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reg_ack) begin
      ack_count++;
      if (ack_prev) begin
        vectors++;
        miscompares++;
        $display("FAIL ack_width: reg_ack high for two consecutive cycles, required one");
      end
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_ack: ack with no pending access");
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.chk) begin
          vectors++;
          if (reg_rdat !== e.rdat) begin
            miscompares++;
            $display("FAIL rdat: got %02h, expected %02h", reg_rdat, e.rdat);
          end
        end
      end
    end
    ack_prev = reg_ack;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  task automatic start(input logic [3:0] a, input logic [7:0] d, input bit wr, input bit rd,
                       input bit chk, input logic [7:0] exp);
    exp_t e;
    e.chk = chk;
    e.rdat = exp;
    sb.push_back(e);
    reg_addr = a;
    reg_wdat = d;
    reg_wr = wr;
    reg_rd = rd;
  endtask

  task automatic wait_ack();
    bit seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (reg_ack) seen = 1;
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL ack_timeout: no ack at addr %0h", reg_addr);
    end
  endtask

  task automatic release_bus();
    reg_wr = 0;
    reg_rd = 0;
    @(negedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge; returns at a negedge with the bus idle.
  task automatic access(input logic [3:0] a, input logic [7:0] d, input bit wr, input bit rd,
                        input bit chk, input logic [7:0] exp);
    start(a, d, wr, rd, chk, exp);
    wait_ack();
    release_bus();
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [7:0] d);
    access(a, d, 1, 0, 0, 8'h00);
  endtask

  task automatic rd_reg(input logic [3:0] a, input logic [7:0] exp);
    access(a, 8'h00, 0, 1, 1, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"},   {7'd0, reg_ack}, 8'h00);
    check({tag, "_rdat"},  reg_rdat, 8'h00);
    check({tag, "_gpo"},   {1'b0, gpo}, 8'h00);
    check({tag, "_mc"},    mc, 8'h00);
    check({tag, "_mc_oe"}, mc_oe, 8'h00);
    check({tag, "_irq"},   {7'd0, irq}, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks0;
    rst = 1; ena = 1; gpi = '0;
    reg_addr = '0; reg_wdat = '0; reg_wr = 0; reg_rd = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    check_reset_outputs("reset");

    // Held read strobe yields exactly one ack
    acks0 = ack_count;
    start(REG_ID, 8'h00, 0, 1, 1, 8'hA5);
    repeat (7) @(negedge clk);
    check("hold_one_ack", 8'(ack_count - acks0), 8'd1);
    release_bus();

    wr_reg(REG_SCRATCH, 8'h3C);
    rd_reg(REG_SCRATCH, 8'h3C);
    wr_reg(REG_GPO, 8'hFF);
    check("gpo", {1'b0, gpo}, 8'h7F);
    rd_reg(REG_GPO, 8'h7F);

    wr_reg(REG_MC, 8'h5A);
    wr_reg(REG_MC_OE, 8'hFF);
    check("mc", mc, 8'h5A);
    check("mc_oe_ctrl0", mc_oe, 8'h00);
    wr_reg(REG_CTRL, 8'h01);
    check("mc_oe_ctrl1", mc_oe, 8'hFF);
    ena = 0;
    @(negedge clk);
    check("mc_oe_ena0", mc_oe, 8'h00);
    ena = 1;
    @(negedge clk);

    // Edge capture latency and irq
    wr_reg(REG_EDGE_MASK, 8'h08);
    gpi[3] = 1;
    @(negedge clk);
    @(negedge clk);
    check("irq_before_edge", {7'd0, irq}, 8'h00);
    @(negedge clk);
    check("irq_at_edge", {7'd0, irq}, 8'h01);
    rd_reg(REG_EDGE, 8'h08);
    ena = 0;
    @(negedge clk);
    check("irq_ena0", {7'd0, irq}, 8'h00);
    ena = 1;
    @(negedge clk);
    wr_reg(REG_EDGE, 8'h08);
    check("irq_cleared", {7'd0, irq}, 8'h00);
    rd_reg(REG_EDGE, 8'h00);

    // W1C in the same cycle as a new rise: set wins
    gpi[3] = 0;
    repeat (4) @(negedge clk);
    gpi[3] = 1;
    @(negedge clk);
    @(negedge clk);
    wr_reg(REG_EDGE, 8'h08);
    check("set_wins_irq", {7'd0, irq}, 8'h01);
    rd_reg(REG_EDGE, 8'h08);
    wr_reg(REG_EDGE, 8'h08);
    rd_reg(REG_EDGE, 8'h00);

    gpi[13:8] = 6'h2A;
    repeat (3) @(negedge clk);
    rd_reg(REG_GPI_HI, 8'h2A);
    rd_reg(REG_GPI_LO, 8'h08);

    rd_reg(4'hC, 8'h00);
    wr_reg(4'hA, 8'h55);
    rd_reg(4'hA, 8'h00);
    wr_reg(REG_ID, 8'h00);
    rd_reg(REG_ID, 8'hA5);
    // Write and read together: write happens, read data holds 0xA5
    acks0 = ack_count;
    access(REG_SCRATCH, 8'h77, 1, 1, 1, 8'hA5);
    check("wr_rd_one_ack", 8'(ack_count - acks0), 8'd1);
    rd_reg(REG_SCRATCH, 8'h77);

    // Reset asserted during ACK with the strobe still held
    acks0 = ack_count;
    start(REG_SCRATCH, 8'h99, 1, 0, 0, 8'h00);
    wait_ack();
    rst = 1;
    repeat (3) @(negedge clk);
    check("rst_no_ack", 8'(ack_count - acks0), 8'd1);
    check_reset_outputs("rst_mid");
    reg_wr = 0;
    rst = 0;
    repeat (2) @(negedge clk);
    rd_reg(REG_SCRATCH, 8'h00);

    repeat (3) @(negedge clk);
    check("sb_empty", 8'(sb.size()), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
